// File: rtl/fpu_op_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpu_op_controller_pkg
// Brief   : Shared encodings for the FPU operation controller: op codes,
//           exception codes, FSM state encodings and status bit positions.
// Revision: 1.0 - initial release
// ============================================================================
package fpu_op_controller_pkg;

  localparam int CNT_W = 5;

  // Operation codes as presented on op_code / dp_op
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Exception codes reported with each result
  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_UNF  = 2'b10;
  localparam logic [1:0] EXC_INV  = 2'b11;

  // Controller FSM states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_EXEC = 3'd2;
  localparam logic [2:0] ST_PACK = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  // Sticky status bit positions
  localparam int STAT_OVF = 0;
  localparam int STAT_UNF = 1;
  localparam int STAT_INV = 2;
  localparam int STAT_TO  = 3;

  // Priority encode the exception flags; a divider timeout reports as invalid
  function automatic logic [1:0] exc_encode(input logic to, input logic ov,
                                            input logic uf, input logic inv);
    logic [1:0] code;
    code = EXC_NONE;
    if (to)       code = EXC_INV;
    else if (ov)  code = EXC_OVF;
    else if (uf)  code = EXC_UNF;
    else if (inv) code = EXC_INV;
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_lat_counter.sv
`default_nettype none
// ============================================================================
// Module  : fpu_lat_counter
// Brief   : Loadable down-counter with zero detect, used to time EXEC.
// Revision: 1.0 - initial release
// ============================================================================
module fpu_lat_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Load takes priority; decrement saturates at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     count <= '0;
    else if (load)               count <= load_val;
    else if (dec && count != '0) count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/fpu_op_controller.sv
`default_nettype none
// ============================================================================
// Module  : fpu_op_controller
// Brief   : Sequences one FPU operation at a time through
//           IDLE -> LOAD -> EXEC -> PACK -> HOLD, reports exceptions and
//           keeps sticky status.
// Revision: 1.0 - initial release
// ============================================================================
module fpu_op_controller
  import fpu_op_controller_pkg::*;
#(
  parameter int ADD_LAT     = 3,
  parameter int MUL_LAT     = 4,
  parameter int DIV_TIMEOUT = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op_code,
  output logic       ready_in,
  output logic       op_load,
  output logic       dp_start,
  output logic [1:0] dp_op,
  input  logic       dp_done,
  input  logic       overflow_flag,
  input  logic       underflow_flag,
  input  logic       invalid_flag,
  output logic       pack_en,
  output logic       result_valid,
  input  logic       result_ready,
  output logic [1:0] exc_code,
  input  logic       clear_status,
  output logic [3:0] status
);

  // Counter preload values: counter holds LAT-1 in the first EXEC cycle
  localparam logic [CNT_W-1:0] ADD_LD = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_TIMEOUT - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             exec_first;
  logic             timeout;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             is_div;
  logic             exec_done;
  logic             div_timeout;
  logic [3:0]       flags;

  assign is_div      = (dp_op == OP_DIV);
  assign exec_done   = (state == ST_EXEC) && (is_div ? (dp_done || cnt_zero) : cnt_zero);
  assign div_timeout = (state == ST_EXEC) && is_div && !dp_done && cnt_zero;

  // Preload value chosen from the op latched at acceptance
  always_comb begin
    load_val = ADD_LD;
    case (dp_op)
      OP_MUL:  load_val = MUL_LD;
      OP_DIV:  load_val = DIV_LD;
      default: load_val = ADD_LD;
    endcase
  end

  fpu_lat_counter #(.WIDTH(CNT_W)) u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_LOAD),
    .load_val (load_val),
    .dec      (state == ST_EXEC),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_EXEC;
      ST_EXEC: if (exec_done) state_nxt = ST_PACK;
      ST_PACK: state_nxt = ST_HOLD;
      ST_HOLD: if (result_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; all decoded from registered state so they clear on reset
  always_comb begin
    ready_in     = (state == ST_IDLE);
    op_load      = (state == ST_LOAD);
    dp_start     = (state == ST_EXEC) && exec_first;
    pack_en      = (state == ST_PACK);
    result_valid = (state == ST_HOLD);
  end

  // Marks the first EXEC cycle for the dp_start pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) exec_first <= 1'b0;
    else     exec_first <= (state == ST_LOAD);
  end

  // Op code captured at acceptance and held until the next acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            dp_op <= OP_ADD;
    else if (state == ST_IDLE && start) dp_op <= op_code;
  end

  // Divider timeout flag, cleared at the start of every operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   timeout <= 1'b0;
    else if (state == ST_LOAD) timeout <= 1'b0;
    else if (div_timeout)      timeout <= 1'b1;
  end

  // Flags as captured in PACK, arranged by status bit position
  always_comb begin
    flags           = '0;
    flags[STAT_OVF] = overflow_flag;
    flags[STAT_UNF] = underflow_flag;
    flags[STAT_INV] = invalid_flag;
    flags[STAT_TO]  = timeout;
  end

  // Exception code registered in PACK and held with the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   exc_code <= EXC_NONE;
    else if (state == ST_PACK) exc_code <= exc_encode(timeout, overflow_flag,
                                                      underflow_flag, invalid_flag);
  end

  // Sticky status; a clear in PACK still keeps that cycle's flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   status <= '0;
    else if (state == ST_PACK) status <= (clear_status ? 4'b0000 : status) | flags;
    else if (clear_status)     status <= '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_op_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpu_op_controller
// Brief   : Scoreboard bench for fpu_op_controller: cycle-exact pulse checks
//           per operation, exception codes queued and matched at handshake.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fpu_op_controller;

  localparam int ADD_LAT     = 3;
  localparam int MUL_LAT     = 4;
  localparam int DIV_TIMEOUT = 31;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op_code;
  logic       ready_in;
  logic       op_load;
  logic       dp_start;
  logic [1:0] dp_op;
  logic       dp_done;
  logic       overflow_flag;
  logic       underflow_flag;
  logic       invalid_flag;
  logic       pack_en;
  logic       result_valid;
  logic       result_ready;
  logic [1:0] exc_code;
  logic       clear_status;
  logic [3:0] status;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] exp_q[$];
  logic [3:0] sb_status = 4'b0000;

  fpu_op_controller #(
    .ADD_LAT     (ADD_LAT),
    .MUL_LAT     (MUL_LAT),
    .DIV_TIMEOUT (DIV_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .op_code        (op_code),
    .ready_in       (ready_in),
    .op_load        (op_load),
    .dp_start       (dp_start),
    .dp_op          (dp_op),
    .dp_done        (dp_done),
    .overflow_flag  (overflow_flag),
    .underflow_flag (underflow_flag),
    .invalid_flag   (invalid_flag),
    .pack_en        (pack_en),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .exc_code       (exc_code),
    .clear_status   (clear_status),
    .status         (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: pop expected exception code when the result is handed over
  always @(negedge clk) begin
    if (!rst && result_valid && result_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("sb_exc_code", exc_code, exp_q.pop_front());
    end
  end

  // One full operation; entered and left at posedge+1 of an IDLE cycle.
  // done_at: EXEC cycle (1-based) in which dp_done is raised for div, 0 = never.
  task automatic do_op(input logic [1:0] op, input logic ov, input logic uf,
                       input logic inv, input int done_at, input int hold,
                       input bit busy_start, input bit clr_pack);
    int         lat;
    bit         to;
    logic [1:0] exc;
    logic [3:0] fl;
    to  = 1'b0;
    lat = (op == 2'b10) ? MUL_LAT : ADD_LAT;
    if (op == 2'b11) begin
      to  = (done_at == 0 || done_at > DIV_TIMEOUT);
      lat = to ? DIV_TIMEOUT : done_at;
    end
    if (to)       exc = 2'b11;
    else if (ov)  exc = 2'b01;
    else if (uf)  exc = 2'b10;
    else if (inv) exc = 2'b11;
    else          exc = 2'b00;
    fl = {to, inv, uf, ov};
    check("ready_before_start", ready_in, 1);
    exp_q.push_back(exc);
    start = 1'b1; op_code = op;
    overflow_flag = ov; underflow_flag = uf; invalid_flag = inv;
    for (int c = 1; c <= 2 + lat; c++) begin
      @(posedge clk); #1;
      start   = busy_start ? 1'($urandom_range(0, 1)) : 1'b0;
      op_code = 2'($urandom);
      if (op == 2'b11) dp_done = (done_at > 0 && c == 1 + done_at);
      else             dp_done = busy_start ? 1'($urandom_range(0, 1)) : 1'b0;
      clear_status = clr_pack && (c == 2 + lat);
      check("pulses", {ready_in, op_load, dp_start, pack_en, result_valid},
            {1'b0, c == 1, c == 2, c == 2 + lat, 1'b0});
      check("dp_op", dp_op, op);
    end
    sb_status = (clr_pack ? 4'b0000 : sb_status) | fl;
    for (int h = 0; h <= hold; h++) begin
      @(posedge clk); #1;
      start        = busy_start ? 1'($urandom_range(0, 1)) : 1'b0;
      op_code      = 2'($urandom);
      dp_done      = 1'b0;
      clear_status = 1'b0;
      overflow_flag = 1'b0; underflow_flag = 1'b0; invalid_flag = 1'b0;
      result_ready = (h == hold);
      check("hold_pulses", {ready_in, op_load, dp_start, pack_en, result_valid}, 5'b00001);
      check("hold_exc_code", exc_code, exc);
      check("hold_status", status, sb_status);
    end
    @(posedge clk); #1;
    start = 1'b0; result_ready = 1'b0;
    check("idle_after_hold", {ready_in, op_load, dp_start, pack_en, result_valid}, 5'b10000);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_code = 2'b00; dp_done = 1'b0;
    overflow_flag = 1'b0; underflow_flag = 1'b0; invalid_flag = 1'b0;
    result_ready = 1'b0; clear_status = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pulses", {ready_in, op_load, dp_start, pack_en, result_valid}, 5'b10000);
    check("rst_dp_op", dp_op, 0);
    check("rst_exc_code", exc_code, 0);
    check("rst_status", status, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(2'b00, 0, 0, 0, 0, 0, 0, 0);   // add, base latency
    do_op(2'b01, 0, 1, 0, 0, 1, 0, 0);   // sub, underflow
    do_op(2'b10, 1, 0, 1, 0, 0, 0, 0);   // mul, overflow beats invalid

    // clear_status while idle drops all sticky bits
    clear_status = 1'b1;
    @(posedge clk); #1;
    clear_status = 1'b0; sb_status = 4'b0000;
    check("clear_idle_status", status, 0);

    do_op(2'b01, 0, 1, 0, 0, 0, 0, 0);   // set underflow again
    do_op(2'b00, 1, 0, 1, 0, 0, 0, 1);   // clear in PACK keeps this op's flags
    check("clear_in_pack_status", status, 4'b0101);

    do_op(2'b11, 0, 0, 0, 7, 0, 0, 0);   // div, done in 7th EXEC cycle
    do_op(2'b11, 0, 0, 0, 1, 0, 0, 0);   // div, done on dp_start cycle
    do_op(2'b11, 0, 0, 0, 31, 0, 0, 0);  // div, done on last allowed cycle
    do_op(2'b11, 0, 1, 0, 0, 0, 0, 0);   // div timeout forces invalid
    check("timeout_status_bit", status[3], 1);
    do_op(2'b10, 0, 0, 0, 0, 10, 1, 0);  // long hold, stray starts ignored

    // reset in the middle of a mul abandons it
    start = 1'b1; op_code = 2'b10;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_exec_pulses", {ready_in, op_load, dp_start, pack_en, result_valid}, 5'b00000);
    rst = 1'b1;
    #1;
    check("async_rst_pulses", {ready_in, op_load, dp_start, pack_en, result_valid}, 5'b10000);
    check("async_rst_dp_op", dp_op, 0);
    check("async_rst_exc_code", exc_code, 0);
    check("async_rst_status", status, 0);
    sb_status = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("post_rst_quiet", {ready_in, pack_en, result_valid}, 3'b100);
    end
    do_op(2'b10, 0, 0, 1, 0, 2, 0, 0);   // normal mul after reset

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_op_controller.md
FPU_OP_CONTROLLER -- requirements
Module: fpu_op_controller

Interface
REQ-001 Parameter ADD_LAT, default 3, EXEC cycles for add/sub (min 1).
REQ-002 Parameter MUL_LAT, default 4, EXEC cycles for mul (min 1).
REQ-003 Parameter DIV_TIMEOUT, default 31, maximum EXEC cycles waiting for dp_done on div.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  operation request; accepted only when ready_in=1.
REQ-007 op_code  in  2  00 add, 01 sub, 10 mul, 11 div; sampled at acceptance.
REQ-008 ready_in  out  1  high only in IDLE.
REQ-009 op_load  out  1  one-cycle pulse: datapath latches operands.
REQ-010 dp_start  out  1  one-cycle pulse: datapath begins the operation.
REQ-011 dp_op  out  2  registered op_code, held stable from LOAD through HOLD.
REQ-012 dp_done  in  1  iterative divider completion (used for div only).
REQ-013 overflow_flag, underflow_flag, invalid_flag  in  1 each  datapath exception flags, valid in PACK.
REQ-014 pack_en  out  1  one-cycle pulse: final packing stage registers its output.
REQ-015 result_valid  out  1  result available; held until result_ready.
REQ-016 result_ready  in  1  consumer accepts result.
REQ-017 exc_code  out  2  00 none, 01 overflow, 10 underflow, 11 invalid; held with result.
REQ-018 clear_status  in  1  clears sticky status.
REQ-019 status  out  4  sticky {timeout, invalid, underflow, overflow}.

Function
REQ-020 FSM states IDLE, LOAD, EXEC, PACK, HOLD, encoded in 3 bits; exactly one active.
REQ-021 IDLE: start=1 -> latch op_code into dp_op, go to LOAD; start while not in IDLE is ignored, never queued.
REQ-022 LOAD: op_load=1 for exactly this cycle; next state EXEC.
REQ-023 EXEC entry cycle: dp_start=1 for exactly one cycle; 5-bit counter loaded with LAT-1 (add/sub ADD_LAT, mul MUL_LAT, div DIV_TIMEOUT-1).
REQ-024 EXEC add/sub/mul: counter decrements each cycle; at counter=0 go to PACK; EXEC lasts exactly LAT cycles; dp_done ignored.
REQ-025 EXEC div: go to PACK on first cycle dp_done=1 (including the dp_start cycle); if counter reaches 0 with dp_done=0, set timeout and go to PACK.
REQ-026 PACK: pack_en=1 for one cycle; exc_code registered with priority overflow > underflow > invalid > none; timeout forces exc_code=11.
REQ-027 PACK: status |= captured flags (timeout into bit 3); clear_status in same cycle -> status = this cycle's flags only.
REQ-028 clear_status in any other state -> status = 0 next cycle.
REQ-029 HOLD: result_valid=1; exc_code stable; result_ready=1 -> IDLE next cycle, result_valid low.
REQ-030 Latency: start accepted at cycle 0 -> LOAD cycle 1, EXEC from cycle 2, PACK cycle 2+LAT, result_valid from cycle 3+LAT.
REQ-031 Back-to-back: ready_in high one cycle after HOLD exit; minimum throughput one op per LAT+4 cycles.
REQ-032 op_load, dp_start, pack_en never overlap.

Reset
REQ-033 rst=1 immediately forces IDLE, counter=0, dp_op=00, exc_code=00, status=0, all pulses and result_valid=0, ready_in=1 after release.
REQ-034 Reset mid-operation abandons the op; no pack_en or result_valid follows.

Structure
REQ-035 Shared package/include holds op_code values, exc_code values, state encodings and the status bit positions.
REQ-036 One sub-module, fpu_lat_counter (load/decrement/zero detect), is natural; the FSM stays in fpu_op_controller.

Verification
REQ-037 Add, ADD_LAT=3: start at cycle 0 -> op_load cycle 1, dp_start cycle 2, pack_en cycle 5, result_valid cycle 6, exc_code=00.
REQ-038 Div, dp_done at 7th EXEC cycle -> pack_en next cycle; div without dp_done -> PACK after 31 EXEC cycles, exc_code=11, status[3]=1.
REQ-039 PACK with overflow=1 and invalid=1 -> exc_code=01, status=0101; clear_status in that PACK -> status=0101 not 0000.
REQ-040 result_ready held low 10 cycles -> result_valid, exc_code stable; start pulses during busy ignored (one op completed).
REQ-041 rst asserted in EXEC of mul -> all outputs reset same cycle, no pack_en afterwards, next start completes normally.
